banco_deslocamento: RTL
=======================

Name: banco_deslocamento

Overview:
- Parametrised bank of CHANNELS circular shift registers, each WIDTH bits, sharing one clock, one mode select (ch1,ch0) and one shift-rate prescaler.
- Each channel drives one serial output bit (its MSB); together the outputs scan a row/column pattern on the display board.
- Adds over the fixed 7x14 bank: run-time parallel load, left/right rotation, programmable shift rate, a position counter and a wrap pulse.

Parameters:
- WIDTH, 14, bits per channel register (>=2).
- CHANNELS, 7, number of channels/serial outputs (>=1).
- DIV, 1, clock cycles per shift step (>=1; DIV=1 means shift every cycle).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ch0  in  1  mode select LSB.
- ch1  in  1  mode select MSB.
- dado  in  CHANNELS*WIDTH  parallel load data; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
- saida  out  CHANNELS  saida[k] = MSB (bit WIDTH-1) of channel k register.
- posicao  out  clog2(WIDTH)  current rotation offset, 0..WIDTH-1.
- volta  out  1  one-cycle pulse when posicao wraps.

Behaviour:
- Reset (rst_n=0 at rising edge) overrides every mode: all channel registers 0, saida=0, posicao=0, prescaler=0, volta=0.
- Mode {ch1,ch0}:
  - 00 HOLD: registers, posicao and prescaler frozen; volta=0.
  - 01 LEFT: rotate left on tick, reg <= {reg[WIDTH-2:0], reg[WIDTH-1]}.
  - 10 RIGHT: rotate right on tick, reg <= {reg[0], reg[WIDTH-1:1]}.
  - 11 LOAD: every cycle, reg_k <= dado slice k, posicao <= 0, prescaler <= 0, volta <= 0. No tick dependence.
- Prescaler (LEFT/RIGHT only):
  - Counts 0..DIV-1 each cycle.
  - tick is asserted when prescaler==DIV-1; prescaler then returns to 0.
  - DIV=1 gives a tick every cycle.
- Latency:
  - A shift takes effect at the edge where tick is true, so the first shift comes DIV cycles after entering LEFT/RIGHT from LOAD or reset.
  - Outputs are registered; no combinational path from ch0/ch1/dado to saida.
- posicao:
  - On a LEFT tick: +1 mod WIDTH.
  - On a RIGHT tick: -1 mod WIDTH.
- volta:
  - Registered; high for exactly the cycle after posicao goes WIDTH-1->0 (LEFT) or 0->WIDTH-1 (RIGHT), otherwise 0.
  - Hence a LEFT rotation of WIDTH ticks restores the loaded pattern and pulses volta once.
- Mode change mid-count:
  - Switching LEFT<->RIGHT keeps the prescaler value; no extra or lost tick.
  - Entering HOLD freezes the prescaler; resuming continues from the frozen count.
- Reset mid-operation: takes effect the same edge regardless of mode or prescaler state; the loaded pattern is lost.
- All channels always shift in lockstep; there is no per-channel enable.

Test Plan:
- Reset with WIDTH=4, CHANNELS=2, DIV=1: drive rst_n=0 for 2 cycles in any mode -> saida=00, posicao=0, volta=0.
- Load, then LEFT: dado=8'b0001_1000 (ch1=0001, ch0=1000) in mode 11 for 1 cycle, then mode 01 for 4 cycles.
  - saida after the load edge = 01 (ch0 MSB=1, ch1 MSB=0).
  - Over the following edges saida goes 00, 00, 10, 01.
  - posicao goes 1, 2, 3, 0.
  - volta is high only in the cycle where posicao returns to 0.
- RIGHT rotation: same load, mode 10 for 1 cycle -> posicao=3, volta=1 that cycle, ch0 reg=0100, ch1 reg=1000, saida=10.
- Prescaler with DIV=3: load, then LEFT -> registers change only on the 3rd, 6th and 9th edges after leaving LOAD.
  - Insert HOLD for 5 cycles after the 4th edge; the next shift then occurs 2 LEFT cycles after resuming.
- Reload mid-rotation: LEFT until posicao=2, then LOAD with new dado -> posicao=0 next edge, registers equal the new dado, no volta pulse.
- Reset mid-rotation: DIV=3, prescaler=1, posicao=2, assert rst_n=0 for 1 cycle -> everything 0.
  - After release in LEFT, the first tick arrives 3 cycles later.

Source files
------------

// File: rtl/banco_deslocamento.sv
// rtl/banco_deslocamento.sv - bank of circular shift registers with shared prescaler, rotation offset and wrap pulse
module banco_deslocamento #(
  parameter int WIDTH    = 14,
  parameter int CHANNELS = 7,
  parameter int DIV      = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ch0,
  input  logic                        ch1,
  input  logic [CHANNELS*WIDTH-1:0]   dado,
  output logic [CHANNELS-1:0]         saida,
  output logic [$clog2(WIDTH)-1:0]    posicao,
  output logic                        volta
);

  localparam int PW = $clog2(WIDTH);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_MAX = CW'(DIV - 1);

  logic [WIDTH-1:0] reg_q [CHANNELS];
  logic [WIDTH-1:0] reg_d [CHANNELS];
  logic [PW-1:0]    pos_q, pos_d;
  logic [CW-1:0]    pre_q, pre_d;
  logic             volta_q, volta_d;
  logic [1:0]       mode;
  logic             tick;

  assign mode = {ch1, ch0};
  assign tick = (pre_q == PRE_MAX);

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) reg_d[k] = reg_q[k];
    pos_d   = pos_q;
    pre_d   = pre_q;
    volta_d = 1'b0;
    case (mode)
      2'b01: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick) begin
          for (int k = 0; k < CHANNELS; k++)
            reg_d[k] = {reg_q[k][WIDTH-2:0], reg_q[k][WIDTH-1]};
          volta_d = (pos_q == POS_MAX);
          pos_d   = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
        end
      end
      2'b10: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick) begin
          for (int k = 0; k < CHANNELS; k++)
            reg_d[k] = {reg_q[k][0], reg_q[k][WIDTH-1:1]};
          volta_d = (pos_q == '0);
          pos_d   = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
        end
      end
      2'b11: begin
        for (int k = 0; k < CHANNELS; k++)
          reg_d[k] = dado[k*WIDTH +: WIDTH];
        pos_d = '0;
        pre_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) reg_q[k] <= '0;
      pos_q   <= '0;
      pre_q   <= '0;
      volta_q <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) reg_q[k] <= reg_d[k];
      pos_q   <= pos_d;
      pre_q   <= pre_d;
      volta_q <= volta_d;
    end
  end

  always_comb begin
    saida = '0;
    for (int k = 0; k < CHANNELS; k++) saida[k] = reg_q[k][WIDTH-1];
  end

  assign posicao = pos_q;
  assign volta   = volta_q;

endmodule
